// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, condition codes and datapath selects.
// Conditional execution is controlled by the COND_EXEC_EN macro (see cond_logic).
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/cond_logic.sv
// NZCV flag register, condition evaluator and registered CondExR.
// With COND_EXEC_EN undefined, CondExR is tied high and every condition executes.
module cond_logic
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] aluflags,
    input  logic [1:0] flagw,
    input  logic       flagen,
    input  logic       condload,
    output logic       condexr
);

    logic [3:0] flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= '0;
        end else if (flagen && condexr) begin
            if (flagw[1]) flags[3:2] <= aluflags[3:2];
            if (flagw[0]) flags[1:0] <= aluflags[1:0];
        end
    end

`ifdef COND_EXEC_EN
    logic n, z, c, v;
    logic condex;

    assign {n, z, c, v} = flags;

    always_comb begin
        condex = 1'b0;
        case (cond)
            COND_EQ: condex = z;
            COND_NE: condex = ~z;
            COND_CS: condex = c;
            COND_CC: condex = ~c;
            COND_MI: condex = n;
            COND_PL: condex = ~n;
            COND_VS: condex = v;
            COND_VC: condex = ~v;
            COND_HI: condex = c & ~z;
            COND_LS: condex = ~(c & ~z);
            COND_GE: condex = (n == v);
            COND_LT: condex = (n != v);
            COND_GT: condex = ~z & (n == v);
            COND_LE: condex = ~(~z & (n == v));
            COND_AL: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    // Captured at the end of DECODE so later states of the instruction see a stable
    // decision even if this instruction's own flag write lands mid-way.
    always_ff @(posedge clk) begin
        if (reset)
            condexr <= 1'b0;
        else if (condload)
            condexr <= condex;
    end
`else
    logic unused_cond;
    assign unused_cond = ^{cond, condload};
    assign condexr = 1'b1;
`endif

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore controller: FSM, instruction decode and datapath select/enable generation.
// Conditional execution is enabled by defining COND_EXEC_EN.
module mc_controller
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [3:0]  State
);

    state_t     state;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [1:0] aluctl;
    logic [1:0] flagw;
    logic       nowrite;
    logic       condexr;
    logic       unused_bits;

    assign op          = Instr[27:26];
    assign funct       = Instr[25:20];
    assign rd          = Instr[15:12];
    assign unused_bits = ^{Instr[19:16], Instr[11:0]};

    assign ImmSrc = op;
    assign RegSrc = {op == 2'b01, op == 2'b10};
    assign State  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    case (op)
                        2'b01:   state <= MEMADR;
                        2'b00:   state <= funct[5] ? EXECI : EXECR;
                        2'b10:   state <= BRANCH;
                        default: state <= FETCH;
                    endcase
                end
                MEMADR: state <= funct[0] ? MEMRD : MEMWR;
                MEMRD:  state <= MEMWB;
                EXECR:  state <= ALUWB;
                EXECI:  state <= ALUWB;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        aluctl  = ALU_ADD;
        nowrite = 1'b1;
        case (funct[4:1])
            4'b0100: begin aluctl = ALU_ADD; nowrite = 1'b0; end
            4'b0010: begin aluctl = ALU_SUB; nowrite = 1'b0; end
            4'b0000: begin aluctl = ALU_AND; nowrite = 1'b0; end
            4'b1100: begin aluctl = ALU_ORR; nowrite = 1'b0; end
            4'b1010: aluctl = ALU_SUB;
            default: aluctl = ALU_ADD;
        endcase
        flagw[1] = funct[0];
        flagw[0] = funct[0] & ((funct[4:1] == 4'b0100) | (funct[4:1] == 4'b0010)
                               | (funct[4:1] == 4'b1010));
    end

    cond_logic u_cond (
        .clk      (clk),
        .reset    (reset),
        .cond     (Instr[31:28]),
        .aluflags (ALUFlags),
        .flagw    (flagw),
        .flagen   ((state == EXECR) || (state == EXECI)),
        .condload (state == DECODE),
        .condexr  (condexr)
    );

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUControl = ALU_ADD;
        if (reset) begin
            // Selects mirror FETCH so the datapath sees a benign setting; all enables held low.
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
        end else begin
            case (state)
                FETCH: begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
                DECODE: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
                MEMADR: ALUSrcB = SRCB_IMM;
                MEMRD:  AdrSrc = 1'b1;
                MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite  = condexr;
                    PCWrite   = condexr & (rd == 4'hF);
                end
                MEMWR: begin
                    AdrSrc   = 1'b1;
                    MemWrite = condexr;
                end
                EXECR: begin
                    ALUSrcB    = SRCB_REG;
                    ALUControl = aluctl;
                end
                EXECI: begin
                    ALUSrcB    = SRCB_IMM;
                    ALUControl = aluctl;
                end
                ALUWB: begin
                    ResultSrc = RES_ALUOUT;
                    RegWrite  = condexr & ~nowrite;
                    PCWrite   = condexr & (rd == 4'hF);
                end
                BRANCH: begin
                    ALUSrcB   = SRCB_IMM;
                    ResultSrc = RES_ALURESULT;
                    PCWrite   = condexr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller; expectations adapt to COND_EXEC_EN.
module tb_mc_controller;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0]  State;

    int total = 0;
    int bad   = 0;

`ifdef COND_EXEC_EN
    localparam logic CONDEN = 1'b1;
`else
    localparam logic CONDEN = 1'b0;
`endif

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .State      (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; Instr = 32'h0; ALUFlags = 4'h0;
        tick(); tick();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", State); end
        total++; if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin bad++;
            $display("FAIL rst_enables: got %b want 0000", {PCWrite, IRWrite, MemWrite, RegWrite}); end
        total++; if ({ALUSrcA, ALUSrcB, AdrSrc} !== 4'b1100) begin bad++;
            $display("FAIL rst_selects: got %b want 1100", {ALUSrcA, ALUSrcB, AdrSrc}); end
        total++; if (dut.u_cond.flags !== 4'b0000) begin bad++;
            $display("FAIL rst_flags: got %b want 0000", dut.u_cond.flags); end
        reset = 1'b0;
        #1;
        total++; if ({State, IRWrite, PCWrite} !== 6'b0000_11) begin bad++;
            $display("FAIL fetch_after_rst: got %b want 000011", {State, IRWrite, PCWrite}); end
    endtask

    task automatic test_ldr();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        Instr = 32'hE5912004;
        for (int i = 0; i < 5; i++) begin
            total++; if (State !== exp_st[i]) begin bad++; $display("FAIL ldr_state[%0d]: got %0d want %0d", i, State, exp_st[i]); end
            total++; if (RegWrite !== (i == 4)) begin bad++; $display("FAIL ldr_regwrite[%0d]: got %b want %b", i, RegWrite, i == 4); end
            total++; if (AdrSrc !== (i == 3)) begin bad++; $display("FAIL ldr_adrsrc[%0d]: got %b want %b", i, AdrSrc, i == 3); end
            if (i == 2) begin
                total++; if ({ALUSrcA, ALUSrcB, ImmSrc, RegSrc} !== 7'b0_01_01_10) begin bad++;
                    $display("FAIL ldr_memadr_sel: got %b want 0010110", {ALUSrcA, ALUSrcB, ImmSrc, RegSrc}); end
            end
            if (i == 4) begin
                total++; if (ResultSrc !== 2'b01) begin bad++; $display("FAIL ldr_resultsrc: got %b want 01", ResultSrc); end
            end
            tick();
        end
        total++; if (State !== 4'd0) begin bad++; $display("FAIL ldr_return: got %0d want 0", State); end
    endtask

    task automatic test_subs_beq(input logic [3:0] aflags, input logic exp_pcw);
        Instr = 32'hE0512002; ALUFlags = aflags;
        tick(); tick();
        total++; if ({State, ALUControl, ALUSrcB} !== 8'b0110_01_00) begin bad++;
            $display("FAIL subs_execr: got %b want 01100100", {State, ALUControl, ALUSrcB}); end
        tick();
        total++; if (dut.u_cond.flags !== aflags) begin bad++; $display("FAIL subs_flags: got %b want %b", dut.u_cond.flags, aflags); end
        total++; if ({State, RegWrite} !== 5'b1000_1) begin bad++; $display("FAIL subs_aluwb: got %b want 10001", {State, RegWrite}); end
        tick();
        Instr = 32'h0A000002; ALUFlags = 4'h0;
        tick(); tick();
        total++; if (State !== 4'd9) begin bad++; $display("FAIL beq_state: got %0d want 9", State); end
        total++; if (PCWrite !== exp_pcw) begin bad++; $display("FAIL beq_pcwrite flags=%b: got %b want %b", aflags, PCWrite, exp_pcw); end
        total++; if (RegSrc !== 2'b01) begin bad++; $display("FAIL beq_regsrc: got %b want 01", RegSrc); end
        tick();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL beq_return: got %0d want 0", State); end
    endtask

    task automatic test_cmp();
        Instr = 32'hE1510002; ALUFlags = 4'b1001;
        tick(); tick();
        total++; if (ALUControl !== 2'b01) begin bad++; $display("FAIL cmp_aluctl: got %b want 01", ALUControl); end
        tick();
        total++; if ({State, RegWrite, PCWrite} !== 6'b1000_00) begin bad++;
            $display("FAIL cmp_aluwb: got %b want 100000", {State, RegWrite, PCWrite}); end
        total++; if (dut.u_cond.flags !== 4'b1001) begin bad++; $display("FAIL cmp_flags: got %b want 1001", dut.u_cond.flags); end
        tick();
    endtask

    task automatic test_add_pc();
        Instr = 32'hE080F001; ALUFlags = 4'b0110;
        tick(); tick();
        total++; if ({State, ALUControl} !== 6'b0110_00) begin bad++; $display("FAIL addpc_exec: got %b want 011000", {State, ALUControl}); end
        tick();
        total++; if ({RegWrite, PCWrite} !== 2'b11) begin bad++; $display("FAIL addpc_wb: got %b want 11", {RegWrite, PCWrite}); end
        total++; if (dut.u_cond.flags !== 4'b1001) begin bad++; $display("FAIL addpc_noflags: got %b want 1001", dut.u_cond.flags); end
        tick();
    endtask

    task automatic test_cond_nv();
        Instr = 32'hF5812000; ALUFlags = 4'h0;
        tick(); tick(); tick();
        total++; if ({State, AdrSrc} !== 5'b0101_1) begin bad++; $display("FAIL nv_memwr: got %b want 01011", {State, AdrSrc}); end
        total++; if (MemWrite !== ~CONDEN) begin bad++; $display("FAIL nv_memwrite: got %b want %b", MemWrite, ~CONDEN); end
        tick();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL nv_return: got %0d want 0", State); end
    endtask

    task automatic test_midreset_undef();
        Instr = 32'hE5912004;
        tick(); tick(); tick();
        total++; if (State !== 4'd3) begin bad++; $display("FAIL mid_memrd: got %0d want 3", State); end
        reset = 1'b1;
        #1;
        total++; if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin bad++;
            $display("FAIL mid_rst_enables: got %b want 0000", {PCWrite, IRWrite, MemWrite, RegWrite}); end
        tick();
        total++; if ({State, RegWrite} !== 5'b0000_0) begin bad++; $display("FAIL mid_rst_fetch: got %b want 00000", {State, RegWrite}); end
        total++; if (dut.u_cond.flags !== 4'b0000) begin bad++; $display("FAIL mid_rst_flags: got %b want 0000", dut.u_cond.flags); end
        reset = 1'b0; Instr = 32'hEC000000;
        #1;
        total++; if ({State, IRWrite} !== 5'b0000_1) begin bad++; $display("FAIL undef_fetch: got %b want 00001", {State, IRWrite}); end
        tick();
        total++; if ({State, PCWrite, RegWrite, MemWrite} !== 7'b0001_000) begin bad++;
            $display("FAIL undef_decode: got %b want 0001000", {State, PCWrite, RegWrite, MemWrite}); end
        tick();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL undef_return: got %0d want 0", State); end
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_subs_beq(4'b0100, 1'b1);
        test_subs_beq(4'b0000, ~CONDEN);
        test_cmp();
        test_add_pc();
        test_cond_nv();
        test_midreset_undef();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
